// File: rtl/game_pkg.sv
// Shared types and constants for the reaction-game round sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAY      = 3'd2,
        ST_ROUND_END = 3'd3,
        ST_GAME_OVER = 3'd4
    } game_state_e;

    localparam logic [7:0] CMD_START    = 8'h53;
    localparam logic [7:0] CMD_ABORT    = 8'h52;
    localparam logic [7:0] HIT_PTS_FAST = 8'd2;
    localparam logic [7:0] HIT_PTS_SLOW = 8'd1;

    // Add two bytes, clamping at 8'hFF instead of wrapping.
    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[8]) begin
            return 8'hFF;
        end else begin
            return sum[7:0];
        end
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second tick generator: counts 0..TICK_CYCLES-1 while enabled, tick on wrap.
module sec_tick_gen #(
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt_r;

    // Cycle counter; clr dominates so every state entry restarts a full period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == CNT_LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = en & ~clr & (cnt_r == CNT_LAST);

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the reaction game: UART commands, countdown, play, result hold.
// Optional high-score register enabled with macro GAME_HISCORE_EN.
module game_round_ctrl
    import game_pkg::*;
#(
    parameter int TICK_CYCLES   = 100_000_000,
    parameter int COUNTDOWN_SEC = 3,
    parameter int RESULT_SEC    = 2,
    parameter int ROUNDS        = 3,
    parameter int FAST_LEVEL    = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic [9:0] timer_level,
    input  logic       timer_end,
    input  logic       target_hit,
    output logic       timer_start,
    output logic       timer_clr,
    output logic [2:0] game_state,
    output logic [1:0] round_num,
    output logic [2:0] countdown,
    output logic [7:0] score,
    output logic       game_over
`ifdef GAME_HISCORE_EN
    ,
    output logic [7:0] best_score
`endif
);

    localparam logic [2:0] CD_INIT    = 3'(COUNTDOWN_SEC);
    localparam logic [2:0] HOLD_LAST  = 3'(RESULT_SEC - 1);
    localparam logic [1:0] LAST_ROUND = 2'(ROUNDS);
    localparam logic [9:0] FAST_LVL   = 10'(FAST_LEVEL);

    game_state_e state_r;
    logic [1:0]  round_r;
    logic [2:0]  countdown_r;
    logic [7:0]  score_r;
    logic [2:0]  hold_cnt_r;
    logic        timer_start_r;
    logic        timer_clr_r;
    logic        game_over_r;

    logic        cmd_start_s;
    logic        cmd_abort_s;
    logic        abort_s;
    logic        run_s;
    logic        tick_clr_s;
    logic        tick_s;
    logic        hold_done_s;
    logic        enter_over_s;
    logic [7:0]  hit_pts_s;

    assign cmd_start_s  = rx_valid & (rx_data == CMD_START);
    assign cmd_abort_s  = rx_valid & (rx_data == CMD_ABORT);
    assign abort_s      = cmd_abort_s & (state_r != ST_IDLE);
    assign run_s        = (state_r == ST_COUNTDOWN) | (state_r == ST_ROUND_END);
    // Holding the counter clear outside the timed states makes each entry start at zero.
    assign tick_clr_s   = ~run_s | abort_s;
    assign hold_done_s  = (state_r == ST_ROUND_END) & tick_s & (hold_cnt_r == HOLD_LAST);
    assign enter_over_s = hold_done_s & ~abort_s & (round_r == LAST_ROUND);

    sec_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .en   (run_s),
        .clr  (tick_clr_s),
        .tick (tick_s)
    );

    // Hit weight depends on how far the timer bar has drained.
    always_comb begin
        hit_pts_s = HIT_PTS_SLOW;
        if (timer_level < FAST_LVL) begin
            hit_pts_s = HIT_PTS_FAST;
        end else begin
            hit_pts_s = HIT_PTS_SLOW;
        end
    end

    // Game sequencer with registered outputs; ABORT overrides every other event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            round_r       <= 2'd0;
            countdown_r   <= 3'd0;
            score_r       <= 8'd0;
            hold_cnt_r    <= 3'd0;
            timer_start_r <= 1'b0;
            timer_clr_r   <= 1'b0;
            game_over_r   <= 1'b0;
        end else begin
            timer_start_r <= 1'b0;
            timer_clr_r   <= 1'b0;
            if (abort_s) begin
                state_r     <= ST_IDLE;
                round_r     <= 2'd0;
                countdown_r <= 3'd0;
                score_r     <= 8'd0;
                hold_cnt_r  <= 3'd0;
                game_over_r <= 1'b0;
                timer_clr_r <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE, ST_GAME_OVER: begin
                        if (cmd_start_s) begin
                            state_r     <= ST_COUNTDOWN;
                            round_r     <= 2'd1;
                            score_r     <= 8'd0;
                            countdown_r <= CD_INIT;
                            game_over_r <= 1'b0;
                        end
                    end
                    ST_COUNTDOWN: begin
                        if (tick_s) begin
                            countdown_r <= countdown_r - 3'd1;
                            if (countdown_r == 3'd1) begin
                                state_r       <= ST_PLAY;
                                timer_start_r <= 1'b1;
                            end
                        end
                    end
                    ST_PLAY: begin
                        if (target_hit) begin
                            score_r <= sat_add8(score_r, hit_pts_s);
                        end
                        if (timer_end) begin
                            state_r    <= ST_ROUND_END;
                            hold_cnt_r <= 3'd0;
                        end
                    end
                    ST_ROUND_END: begin
                        if (enter_over_s) begin
                            state_r     <= ST_GAME_OVER;
                            game_over_r <= 1'b1;
                        end else if (hold_done_s) begin
                            state_r     <= ST_COUNTDOWN;
                            round_r     <= round_r + 2'd1;
                            countdown_r <= CD_INIT;
                        end else if (tick_s) begin
                            hold_cnt_r <= hold_cnt_r + 3'd1;
                        end
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        round_r     <= 2'd0;
                        countdown_r <= 3'd0;
                        score_r     <= 8'd0;
                        hold_cnt_r  <= 3'd0;
                        game_over_r <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef GAME_HISCORE_EN
    logic [7:0] best_r;

    // Best score survives ABORT; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_r <= 8'd0;
        end else if (enter_over_s && (score_r > best_r)) begin
            best_r <= score_r;
        end else begin
            best_r <= best_r;
        end
    end

    assign best_score = best_r;
`endif

    assign game_state  = state_r;
    assign round_num   = round_r;
    assign countdown   = countdown_r;
    assign score       = score_r;
    assign timer_start = timer_start_r;
    assign timer_clr   = timer_clr_r;
    assign game_over   = game_over_r;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed plus randomized bench for game_round_ctrl against a timestamp-based game model.
module tb_game_round_ctrl;

    localparam int TICK = 10;
    localparam int CD   = 3;
    localparam int RS   = 2;
    localparam int RN   = 2;
    localparam int FL   = 100;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [9:0] timer_level;
    logic       timer_end;
    logic       target_hit;
    logic       timer_start;
    logic       timer_clr;
    logic [2:0] game_state;
    logic [1:0] round_num;
    logic [2:0] countdown;
    logic [7:0] score;
    logic       game_over;
`ifdef GAME_HISCORE_EN
    logic [7:0] best_score;
`endif

    game_round_ctrl #(
        .TICK_CYCLES  (TICK),
        .COUNTDOWN_SEC(CD),
        .RESULT_SEC   (RS),
        .ROUNDS       (RN),
        .FAST_LEVEL   (FL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .timer_level(timer_level),
        .timer_end  (timer_end),
        .target_hit (target_hit),
        .timer_start(timer_start),
        .timer_clr  (timer_clr),
        .game_state (game_state),
        .round_num  (round_num),
        .countdown  (countdown),
        .score      (score),
        .game_over  (game_over)
`ifdef GAME_HISCORE_EN
        ,
        .best_score (best_score)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase, round, score, best, and the edge number at which the phase began.
    int m_state, m_round, m_score, m_best, m_entry, n;
    int m_tstart, m_tclr;
    int checks, passes, fails;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_countdown();
        if (m_state == 1) return CD - (n - m_entry) / TICK;
        return 0;
    endfunction

    task automatic model_reset();
        m_state = 0; m_round = 0; m_score = 0; m_best = 0;
        m_tstart = 0; m_tclr = 0; m_entry = n;
    endtask

    task automatic new_game();
        m_state = 1; m_round = 1; m_score = 0; m_entry = n;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic h,
                              input logic te, input logic [9:0] lv);
        bit start, abort;
        int el;
        start = v && (d == 8'h53);
        abort = v && (d == 8'h52);
        el = n - m_entry;
        m_tstart = 0;
        m_tclr = 0;
        if (abort && m_state != 0) begin
            m_state = 0; m_round = 0; m_score = 0; m_tclr = 1; m_entry = n;
        end else if (m_state == 0 || m_state == 4) begin
            if (start) new_game();
        end else if (m_state == 1) begin
            if (el == CD * TICK) begin
                m_state = 2; m_tstart = 1; m_entry = n;
            end
        end else if (m_state == 2) begin
            if (h) begin
                m_score = m_score + ((lv < FL) ? 2 : 1);
                if (m_score > 255) m_score = 255;
            end
            if (te) begin
                m_state = 3; m_entry = n;
            end
        end else if (m_state == 3) begin
            if (el == RS * TICK) begin
                if (m_round == RN) begin
                    m_state = 4;
                    if (m_score > m_best) m_best = m_score;
                end else begin
                    m_round = m_round + 1; m_state = 1;
                end
                m_entry = n;
            end
        end
    endtask

    task automatic check_all();
        chk("game_state", game_state, m_state);
        chk("round_num", round_num, m_round);
        chk("countdown", countdown, exp_countdown());
        chk("score", score, m_score);
        chk("game_over", game_over, (m_state == 4) ? 1 : 0);
        chk("timer_start", timer_start, m_tstart);
        chk("timer_clr", timer_clr, m_tclr);
`ifdef GAME_HISCORE_EN
        chk("best_score", best_score, m_best);
`endif
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic h,
                       input logic te, input logic [9:0] lv);
        rx_valid = v; rx_data = d; target_hit = h; timer_end = te; timer_level = lv;
        n++;
        if (reset) model_reset();
        else model_edge(v, d, h, te, lv);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 10'd500);
    endtask

    task automatic wait_model(input int s, input int budget);
        int b;
        b = 0;
        while (m_state != s && b < budget) begin
            idle(1);
            b++;
        end
        chk("wait_reach", game_state, s);
    endtask

    task automatic hits(input int k, input logic [9:0] lv);
        for (int i = 0; i < k; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, lv);
    endtask

    int t_start;
    int r;

    initial begin
        checks = 0; passes = 0; fails = 0; n = 0;
        rx_valid = 1'b0; rx_data = 8'h00; target_hit = 1'b0; timer_end = 1'b0;
        timer_level = 10'd500;
        reset = 1'b1;
        model_reset();
        idle(2);
        reset = 1'b0;
        idle(2);

        // Test 1: async reset mid-PLAY, then START timing
        cyc(1'b1, 8'h53, 1'b0, 1'b0, 10'd500);
        wait_model(2, 40);
        hits(2, 10'd50);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        idle(2);
        reset = 1'b0;
        idle(1);
        cyc(1'b1, 8'h53, 1'b0, 1'b0, 10'd500);
        chk("start_cd", countdown, 3);
        chk("start_round", round_num, 1);
        t_start = n;
        for (int i = 0; i < 60 && timer_start !== 1'b1; i++) idle(1);
        chk("start_latency", n - t_start, 30);

        // Test 2: fast + slow hit, then hit coinciding with timer_end
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 10'd50);
        cyc(1'b0, 8'h00, 1'b1, 1'b0, 10'd150);
        chk("score_fast_slow", score, 3);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 10'd150);
        chk("score_hit_end", score, 4);
        chk("state_hit_end", game_state, 3);

        // Test 3: finish game, restart from GAME_OVER
        wait_model(2, 80);
        chk("round_two", round_num, 2);
        cyc(1'b0, 8'h00, 1'b0, 1'b1, 10'd500);
        wait_model(4, 40);
        chk("game_over_flag", game_over, 1);
        cyc(1'b1, 8'h53, 1'b0, 1'b0, 10'd500);
        chk("restart_score", score, 0);

        // Test 4: abort during countdown, abort in IDLE
        idle(10);
        chk("cd_before_abort", countdown, 2);
        cyc(1'b1, 8'h52, 1'b0, 1'b0, 10'd500);
        chk("abort_idle", game_state, 0);
        chk("abort_clr", timer_clr, 1);
        idle(40);
        cyc(1'b1, 8'h52, 1'b0, 1'b0, 10'd500);
        chk("abort_in_idle_clr", timer_clr, 0);

        // Test 5: saturation and ignored events
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 10'd5);
        cyc(1'b1, 8'h53, 1'b0, 1'b0, 10'd500);
        cyc(1'b0, 8'h00, 1'b1, 1'b1, 10'd5);
        cyc(1'b1, 8'h53, 1'b0, 1'b0, 10'd500);
        cyc(1'b1, 8'h41, 1'b0, 1'b0, 10'd500);
        wait_model(2, 40);
        hits(130, 10'd5);
        chk("score_sat", score, 255);
        cyc(1'b1, 8'h53, 1'b0, 1'b0, 10'd500);
        chk("start_in_play", game_state, 2);
        cyc(1'b1, 8'h52, 1'b0, 1'b0, 10'd500);

        // Test 6: best score across two games, kept through abort
        for (int g = 0; g < 2; g++) begin
            cyc(1'b1, 8'h53, 1'b0, 1'b0, 10'd500);
            wait_model(2, 40);
            hits((g == 0) ? 5 : 3, 10'd500);
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 10'd500);
            wait_model(2, 60);
            cyc(1'b0, 8'h00, 1'b0, 1'b1, 10'd500);
            wait_model(4, 40);
        end
        chk("game2_score", score, 3);
`ifdef GAME_HISCORE_EN
        chk("best_after_two", best_score, 5);
`endif
        cyc(1'b1, 8'h53, 1'b0, 1'b0, 10'd500);
        cyc(1'b1, 8'h52, 1'b0, 1'b0, 10'd500);
`ifdef GAME_HISCORE_EN
        chk("best_after_abort", best_score, 5);
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic       v;
            logic [7:0] d;
            r = $urandom_range(0, 399);
            if (r < 4) begin
                v = 1'b1; d = 8'h53;
            end else if (r == 4) begin
                v = 1'b1; d = 8'h52;
            end else if (r < 12) begin
                v = 1'b1; d = 8'($urandom_range(0, 255));
            end else begin
                v = 1'b0; d = 8'($urandom_range(0, 255));
            end
            cyc(v, d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                10'($urandom_range(0, 1023)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
